serial_decoder: RTL

SERIAL_DECODER -- requirements
Module: serial_decoder

---
 rtl/serial_pkg.sv | 12 +
 rtl/bit_counter.sv | 31 +++
 rtl/serial_decoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared frame constants and FSM encoding for the serial link
package serial_pkg;

   localparam int FRAME_BITS = 8;
   localparam int CNT_W      = $clog2(FRAME_BITS);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - frame bit counter with clear, load-to-1, increment and last-bit flag
module bit_counter
   import serial_pkg::*;
#(
   parameter int WIDTH = CNT_W,
   parameter int LAST  = FRAME_BITS - 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= WIDTH'(1);
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign last = (count == WIDTH'(LAST));

endmodule

// File: rtl/serial_decoder.sv
// rtl/serial_decoder.sv - LSB-first serial-to-byte decoder with one-deep output hold and sticky error flags
module serial_decoder
   import serial_pkg::*;
#(
   parameter int FRAME_BITS = serial_pkg::FRAME_BITS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  serialIn,
   input  logic                  frameStart,
   input  logic                  messageReady,
   input  logic                  clearFlags,
   output logic [FRAME_BITS-1:0] message,
   output logic                  messageValid,
   output logic                  overrun,
   output logic                  frameError
);

   localparam int CW = $clog2(FRAME_BITS);

   state_t                state, state_next;
   logic [CW-1:0]         count;
   logic                  last;
   logic                  cnt_clear, cnt_load, cnt_inc;
   logic                  start, capture, complete, abort;
   logic [FRAME_BITS-1:0] shreg;
   logic [FRAME_BITS-1:0] completed_byte;

   bit_counter #(
      .WIDTH (CW),
      .LAST  (FRAME_BITS - 1)
   ) u_bit_counter (
      .clock (clock),
      .reset (reset),
      .clear (cnt_clear),
      .load  (cnt_load),
      .inc   (cnt_inc),
      .count (count),
      .last  (last)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = frameStart ? SHIFT : IDLE;
         SHIFT:   state_next = frameStart ? SHIFT : (last ? IDLE : SHIFT);
         default: state_next = IDLE;
      endcase
   end

   // A frameStart inside a frame restarts rather than completes, even on the last bit.
   always_comb begin
      cnt_clear = 1'b0;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
      start     = 1'b0;
      capture   = 1'b0;
      complete  = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (frameStart) begin
               start    = 1'b1;
               cnt_load = 1'b1;
            end
         end
         SHIFT: begin
            if (frameStart) begin
               start    = 1'b1;
               abort    = 1'b1;
               cnt_load = 1'b1;
            end else if (last) begin
               complete  = 1'b1;
               cnt_clear = 1'b1;
            end else begin
               capture = 1'b1;
               cnt_inc = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // The final bit goes straight into the output register instead of through shreg.
   always_comb begin
      completed_byte                 = shreg;
      completed_byte[FRAME_BITS-1]   = serialIn;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shreg        <= '0;
         message      <= '0;
         messageValid <= 1'b0;
         overrun      <= 1'b0;
         frameError   <= 1'b0;
      end else begin
         if (start) begin
            shreg <= {{(FRAME_BITS-1){1'b0}}, serialIn};
         end else if (capture) begin
            shreg[count] <= serialIn;
         end

         if (complete && (!messageValid || messageReady)) begin
            message      <= completed_byte;
            messageValid <= 1'b1;
         end else if (messageValid && messageReady) begin
            messageValid <= 1'b0;
         end

         if (complete && messageValid && !messageReady) begin
            overrun <= 1'b1;
         end else if (clearFlags) begin
            overrun <= 1'b0;
         end

         if (abort) begin
            frameError <= 1'b1;
         end else if (clearFlags) begin
            frameError <= 1'b0;
         end
      end
   end

endmodule
